// File: rtl/adc_capture_pkg.sv
// Shared types and constants for the ADC capture packet path.
// Holds the framer state encoding, header tag and default bus widths.
package adc_capture_pkg;
  localparam int DATA_W_DEF = 18;
  localparam int SEQ_W_DEF  = 16;
  localparam int CNT_W      = 16;
  localparam logic [1:0] HDR_TAG = 2'b10;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WAIT_IDLE,
    ST_HEADER,
    ST_PAYLOAD,
    ST_GAP,
    ST_DONE
  } state_e;

  // Idle length and packet count go straight into their counters at start,
  // so only the settings consulted later in the capture are shadowed here.
  typedef struct packed {
    logic [7:0]  gap;
    logic [15:0] pkt_len;
    logic        self_test;
  } cfg_t;
endpackage

// File: rtl/adc_pkt_cnt.sv
// Loadable down-counter with zero flag; saturates at zero.
// Shared by the idle/gap timer, payload word count and packet count.
module adc_pkt_cnt #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rstn,
  input  logic         load,
  input  logic         dec,
  input  logic [W-1:0] load_val,
  output logic         zero
);
  logic [W-1:0] cnt;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn)              cnt <= '0;
    else if (load)          cnt <= load_val;
    else if (dec && !zero)  cnt <= cnt - 1'b1;
  end

  assign zero = (cnt == '0);
endmodule

// File: rtl/adc_pkt_framer.sv
// Frames captured ADC words (or a self-test ramp) into header+payload packets
// for the pad interface. adc_data/adc_data_valid are registered from the state.
module adc_pkt_framer
  import adc_capture_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int SEQ_W  = SEQ_W_DEF
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              capture_start,
  input  logic              self_test_mode,
  input  logic [15:0]       cfg_pkt_idle_length,
  input  logic [7:0]        cfg_pktctrl_gap,
  input  logic [15:0]       cfg_pkt_len,
  input  logic [15:0]       cfg_pkt_num,
  input  logic [DATA_W-1:0] fifo_rdata,
  input  logic              fifo_empty,
  output logic              fifo_rd_en,
  output logic [DATA_W-1:0] adc_data,
  output logic              adc_data_valid,
  output logic              busy,
  output logic              done
);
  state_e             state, nxt;
  cfg_t               cfg;
  logic [SEQ_W-1:0]   seq;
  logic [DATA_W-1:0]  ramp;
  logic [DATA_W-1:0]  hdr, data_nxt;
  logic               valid_nxt, word_take, last_word, start_ok;
  logic               t_load, t_dec, t_zero, w_zero, p_zero;
  logic [CNT_W-1:0]   t_val;

  assign start_ok  = (state == ST_IDLE) && capture_start;
  assign last_word = word_take && w_zero;

  // One timer covers both the pre-header idle and the post-packet gap.
  // WAIT_IDLE runs idle+1 cycles, so the header reaches the pads idle+2 edges
  // after the start edge; the gap timer is loaded with gap-1 for exactly gap cycles.
  assign t_load = start_ok || (last_word && cfg.gap != 8'd0);
  assign t_val  = start_ok ? cfg_pkt_idle_length : {8'd0, cfg.gap - 8'd1};
  assign t_dec  = (state == ST_WAIT_IDLE) || (state == ST_GAP);

  adc_pkt_cnt #(.W(CNT_W)) u_tcnt (
    .clk(clk), .rstn(rstn), .load(t_load), .dec(t_dec),
    .load_val(t_val), .zero(t_zero)
  );

  adc_pkt_cnt #(.W(CNT_W)) u_wcnt (
    .clk(clk), .rstn(rstn), .load(state == ST_HEADER), .dec(word_take),
    .load_val(cfg.pkt_len - 16'd1), .zero(w_zero)
  );

  // Counts packets still to send; decremented as each header goes out.
  adc_pkt_cnt #(.W(CNT_W)) u_pcnt (
    .clk(clk), .rstn(rstn), .load(start_ok), .dec(state == ST_HEADER),
    .load_val(cfg_pkt_num), .zero(p_zero)
  );

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) state <= ST_IDLE;
    else       state <= nxt;
  end

  always_comb begin
    nxt = state;
    case (state)
      ST_IDLE:      if (start_ok) nxt = ST_WAIT_IDLE;
      ST_WAIT_IDLE: if (t_zero)   nxt = ST_HEADER;
      ST_HEADER:    nxt = ST_PAYLOAD;
      ST_PAYLOAD:   if (last_word) begin
                      if (cfg.gap != 8'd0) nxt = ST_GAP;
                      else                 nxt = p_zero ? ST_DONE : ST_HEADER;
                    end
      ST_GAP:       if (t_zero) nxt = p_zero ? ST_DONE : ST_HEADER;
      ST_DONE:      nxt = ST_IDLE;
      default:      nxt = ST_IDLE;
    endcase
  end

  always_comb begin
    fifo_rd_en = 1'b0;
    word_take  = 1'b0;
    valid_nxt  = 1'b0;
    data_nxt   = '0;
    hdr        = '0;
    hdr[DATA_W-1 -: 2] = HDR_TAG;
    hdr[SEQ_W-1:0]     = seq;
    case (state)
      ST_HEADER: begin
        valid_nxt = 1'b1;
        data_nxt  = hdr;
      end
      ST_PAYLOAD: begin
        if (cfg.self_test) begin
          word_take = 1'b1;
          data_nxt  = ramp;
        end else begin
          fifo_rd_en = !fifo_empty;
          word_take  = !fifo_empty;
          data_nxt   = fifo_rdata;
        end
        valid_nxt = word_take;
      end
      default: ;
    endcase
  end

  assign busy = (state != ST_IDLE);
  assign done = (state == ST_DONE);

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      cfg  <= '0;
      seq  <= '0;
      ramp <= '0;
    end else begin
      if (start_ok) begin
        cfg  <= '{gap: cfg_pktctrl_gap, pkt_len: cfg_pkt_len, self_test: self_test_mode};
        seq  <= '0;
        ramp <= '0;
      end else begin
        if (last_word)                   seq  <= seq + 1'b1;
        if (word_take && cfg.self_test)  ramp <= ramp + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      adc_data       <= '0;
      adc_data_valid <= 1'b0;
    end else begin
      adc_data_valid <= valid_nxt;
      if (valid_nxt) adc_data <= data_nxt;
    end
  end
endmodule
